// File: rtl/ring_fifo_2n.sv
// ring_fifo_2n: synchronous circular FIFO of 2^ADDR_W entries.
// Wrap is done by masking the pointer with (DEPTH-1). The pointers carry one extra
// lap bit, so a full FIFO can be told apart from an empty one.
//
// Handshake, both sides: a transfer happens at a rising edge when valid and ready
// are both 1. The ready/valid outputs come only from registered pointers. They never
// depend combinationally on the partner's valid/ready.
module ring_fifo_2n #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int AF_LEVEL = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic [ADDR_W:0]   high_water
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   AF_THRESH = (ADDR_W+1)'(AF_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   high_water_q, high_water_d;
  logic              almost_full_q, almost_full_d;

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  assign wr_addr = wr_ptr_q[ADDR_W-1:0] & ADDR_MASK;
  assign rd_addr = rd_ptr_q[ADDR_W-1:0] & ADDR_MASK;

  // The FIFO is empty when the pointers match. It is full when only the lap bits differ.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid  && in_ready;
  assign pop       = out_valid && out_ready;

  // The head sample is shown only while it is valid, so the bus idles at zero.
  assign out_data = out_valid ? mem[rd_addr] : '0;

  assign count       = count_q;
  assign almost_full = almost_full_q;
  assign high_water  = high_water_q;

  // Next-state: pointers, occupancy counter and the level flags derived from it.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    high_water_d  = high_water_q;
    almost_full_d = almost_full_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    almost_full_d = (count_d >= AF_THRESH);
    high_water_d  = (count_d > high_water_q) ? count_d : high_water_q;
  end

  // State registers. A synchronous reset discards every entry and overrides any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      high_water_q  <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      high_water_q  <= high_water_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Sample storage. Contents are not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_addr] <= in_data;
  end

endmodule

// File: tb/tb_ring_fifo_2n.sv
// tb_ring_fifo_2n: scoreboard bench for ring_fifo_2n using the default parameters.
module tb_ring_fifo_2n;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int AF_LVL = 48;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [ADDR_W:0]   count;
  logic              almost_full;
  logic [ADDR_W:0]   high_water;

  ring_fifo_2n #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(AF_LVL)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full),
    .high_water  (high_water)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [DATA_W-1:0] exp_q[$];
  int m_count;
  int m_hw;
  int n_checks;
  int n_errors;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Driver: run one clock cycle. Before the edge, check the handshake outputs and
  // the head sample against the model. After the edge, check the registered outputs.
  task automatic drive_cycle(input logic iv, input logic [DATA_W-1:0] d, input logic ordy);
    logic do_push, do_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    check_val("in_ready", 32'(in_ready), 32'(m_count != DEPTH));
    check_val("out_valid", 32'(out_valid), 32'(m_count != 0));
    if (m_count != 0) check_val("out_data", 32'(out_data), 32'(exp_q[0]));
    else              check_val("out_data_idle", 32'(out_data), 32'd0);
    do_push = iv && (m_count != DEPTH);
    do_pop  = ordy && (m_count != 0);
    @(posedge clk);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(d);
    m_count = m_count + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    if (m_count > m_hw) m_hw = m_count;
    #1;
    check_val("count", 32'(count), 32'(m_count));
    check_val("almost_full", 32'(almost_full), 32'(m_count >= AF_LVL));
    check_val("high_water", 32'(high_water), 32'(m_hw));
  endtask

  task automatic do_reset(input logic iv, input logic ordy);
    rst       = 1'b1;
    in_valid  = iv;
    in_data   = 8'hEE;
    out_ready = ordy;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_hw    = 0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    m_count   = 0;
    m_hw      = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    do_reset(1'b0, 1'b0);

    // Reset then idle
    repeat (2) drive_cycle(1'b0, 8'h00, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b1);

    // Fill with 0x00..0x3F, then one refused push of 0xAA
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, DATA_W'(i), 1'b0);
    drive_cycle(1'b1, 8'hAA, 1'b0);

    // Drain completely, plus one extra pop attempt on empty
    for (int i = 0; i < DEPTH + 1; i++) drive_cycle(1'b0, 8'h00, 1'b1);

    // Wrap stress: 48 in, 48 out, then 100 cycles of simultaneous push+pop
    for (int i = 0; i < 48; i++) drive_cycle(1'b1, DATA_W'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 48; i++) drive_cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 100; i++) drive_cycle(1'b1, DATA_W'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, DATA_W'(i), 1'b0);
    for (int i = 0; i < 100; i++) drive_cycle(1'b1, DATA_W'($urandom_range(0, 255)), 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      drive_cycle(1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));

    // Mid-operation reset with count=20 and a same-cycle push and pop
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive_cycle(1'b1, DATA_W'(8'h30 + i), 1'b0);
    do_reset(1'b1, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b0);
    drive_cycle(1'b1, 8'h5A, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b0);

    // Push and pop together while full: only the pop happens
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, DATA_W'(8'hC0 ^ i), 1'b0);
    drive_cycle(1'b1, 8'h77, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b0);
    drive_cycle(1'b1, 8'h66, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) drive_cycle(1'b0, 8'h00, 1'b1);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
